ssp_tx_unit: RTL and testbench

Transmit unit of the serial synchronous port. Accepts bus byte writes into a 4-entry TX FIFO, serialises each byte MSB-first with a one-period frame pulse, and drives the serial clock, data and frame-sync pins. Its FIFO-full flag is the `ssp_intr[1]` input consumed by the clock-management unit, which stalls phase generation while the FIFO is full.

---
 rtl/ssp_pkg.sv | 14 +
 rtl/ssp_tx_fifo.sv | 82 ++++++++
 rtl/ssp_tx_unit.sv | 137 +++++++++++++
 tb/tb_ssp_tx_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// Shared types and default sizes for the serial synchronous port.
// Both the transmit unit and its FIFO import this package.
package ssp_pkg;

    localparam int SSP_DATA_W   = 8;
    localparam int SSP_TX_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        SHIFT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/ssp_tx_fifo.sv
// Transmit FIFO: small circular buffer with an occupancy counter.
// It also provides registered full/empty flags and a drop pulse.
module ssp_tx_fifo
    import ssp_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int DEPTH  = SSP_TX_DEPTH
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic              wr_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr_reg;
    logic [PTR_W-1:0]  rptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              full_reg;
    logic              empty_reg;
    logic              wr_drop_reg;
    logic              push_ok;
    logic              pop_ok;

    // Acceptance uses the registered flags, so a same-cycle pop never frees a slot.
    assign push_ok = push & ~full_reg;
    assign pop_ok  = pop & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset: contents are invalidated by clearing the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            empty_reg   <= 1'b1;
            wr_drop_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_reg <= rptr_reg + PTR_W'(1);
            end
            count_reg   <= count_next;
            full_reg    <= (count_next == FULL_CNT);
            empty_reg   <= (count_next == '0);
            wr_drop_reg <= push & full_reg;
        end
    end

    assign pop_data = mem[rptr_reg];
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign wr_drop  = wr_drop_reg;

endmodule

// File: rtl/ssp_tx_unit.sv
// Serial synchronous port transmitter: clk/2 serial clock, frame-sync pulse,
// MSB-first shifter fed from the TX FIFO, with back-to-back frames.
module ssp_tx_unit
    import ssp_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int DEPTH  = SSP_TX_DEPTH
) (
    input  logic              clk_i,
    input  logic              clear_n_i,
    input  logic              psel_i,
    input  logic              pwrite_i,
    input  logic [DATA_W-1:0] pwdata_i,
    output logic              sspclkout_o,
    output logic              ssptxd_o,
    output logic              sspfssout_o,
    output logic              tx_full_o,
    output logic              tx_empty_o,
    output logic              tx_busy_o,
    output logic              wr_drop_o
);

    localparam int BIT_W = $clog2(DATA_W);

    tx_state_t         state_reg;
    tx_state_t         state_next;
    logic              div_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [DATA_W-1:0] shreg_next;
    logic [BIT_W-1:0]  bitcnt_reg;
    logic [BIT_W-1:0]  bitcnt_next;
    logic              txd_reg;
    logic              txd_next;
    logic              fss_reg;
    logic              fss_next;
    logic              tick;
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] pop_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;

    assign push = psel_i & pwrite_i;

    ssp_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .clear_n   (clear_n_i),
        .push      (push),
        .push_data (pwdata_i),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .wr_drop   (fifo_drop)
    );

    // A tick is the clk edge on which the serial clock falls.
    assign tick = div_reg;

    always_comb begin
        state_next  = state_reg;
        shreg_next  = shreg_reg;
        bitcnt_next = bitcnt_reg;
        txd_next    = txd_reg;
        fss_next    = fss_reg;
        pop         = 1'b0;
        if (tick) begin
            case (state_reg)
                IDLE: begin
                    pop = ~fifo_empty;
                end
                FRAME: begin
                    fss_next    = 1'b0;
                    txd_next    = shreg_reg[DATA_W-1];
                    bitcnt_next = BIT_W'(DATA_W - 1);
                    state_next  = SHIFT;
                end
                SHIFT: begin
                    if (bitcnt_reg != '0) begin
                        shreg_next  = {shreg_reg[DATA_W-2:0], 1'b0};
                        txd_next    = shreg_reg[DATA_W-2];
                        bitcnt_next = bitcnt_reg - BIT_W'(1);
                    end else begin
                        // Last bit has had its full period: chain the next frame or go idle.
                        pop      = ~fifo_empty;
                        txd_next = 1'b0;
                        if (fifo_empty) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    txd_next   = 1'b0;
                    fss_next   = 1'b0;
                end
            endcase
            if (pop) begin
                shreg_next = pop_data;
                fss_next   = 1'b1;
                txd_next   = 1'b0;
                state_next = FRAME;
            end
        end
    end

    always_ff @(posedge clk_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            state_reg  <= IDLE;
            div_reg    <= 1'b0;
            shreg_reg  <= '0;
            bitcnt_reg <= '0;
            txd_reg    <= 1'b0;
            fss_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= ~div_reg;
            shreg_reg  <= shreg_next;
            bitcnt_reg <= bitcnt_next;
            txd_reg    <= txd_next;
            fss_reg    <= fss_next;
        end
    end

    assign sspclkout_o = div_reg;
    assign ssptxd_o    = txd_reg;
    assign sspfssout_o = fss_reg;
    assign tx_full_o   = fifo_full;
    assign tx_empty_o  = fifo_empty;
    assign tx_busy_o   = (state_reg != IDLE);
    assign wr_drop_o   = fifo_drop;

endmodule

// File: tb/tb_ssp_tx_unit.sv
// Scoreboard bench for ssp_tx_unit: a queue-based reference model predicts
// FIFO occupancy and frame timing; a monitor decodes the serial frames.
module tb_ssp_tx_unit;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       clear_n = 1'b1;
    logic       psel = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] pwdata = 8'h00;
    logic       sspclkout, ssptxd, sspfssout, tx_full, tx_empty, tx_busy, wr_drop;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ssp_tx_unit #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .clear_n_i   (clear_n),
        .psel_i      (psel),
        .pwrite_i    (pwrite),
        .pwdata_i    (pwdata),
        .sspclkout_o (sspclkout),
        .ssptxd_o    (ssptxd),
        .sspfssout_o (sspfssout),
        .tx_full_o   (tx_full),
        .tx_empty_o  (tx_empty),
        .tx_busy_o   (tx_busy),
        .wr_drop_o   (wr_drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, serial engine as "ticks left in frame"
    // (DW+1 ticks per frame: one frame-sync tick plus one per data bit).
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    bit         m_div;
    int         m_left;
    bit         m_drop;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_q.delete();
            exp_q.delete();
            m_div  = 1'b0;
            m_left = 0;
            m_drop = 1'b0;
        end else begin
            int sz;
            sz = m_q.size();
            m_drop = psel && pwrite && (sz == DEPTH);
            if (m_div) begin
                if (m_left <= 1 && sz > 0) begin
                    m_q.delete(0);
                    m_left = DW + 1;
                end else if (m_left > 0) begin
                    m_left--;
                end
            end
            if (psel && pwrite && sz < DEPTH) begin
                m_q.push_back(pwdata);
                exp_q.push_back(pwdata);
            end
            m_div = !m_div;
        end
    end

    // Monitor: flag checks every cycle and frame decoding against exp_q.
    bit          coll = 1'b0;
    int          nbits = 0;
    int          fss_run = 0;
    logic [15:0] samp;
    logic [7:0]  mon_byte;

    always @(negedge clk) begin
        if (!clear_n) begin
            coll    = 1'b0;
            nbits   = 0;
            fss_run = 0;
        end else begin
            check("sspclkout", sspclkout, m_div);
            check("tx_full", tx_full, m_q.size() == DEPTH);
            check("tx_empty", tx_empty, m_q.size() == 0);
            check("tx_busy", tx_busy, m_left > 0);
            check("wr_drop", wr_drop, m_drop);
            check("sspfssout", sspfssout, m_left == DW + 1);
            if (sspfssout) begin
                if (coll && nbits > 0) begin
                    tests++;
                    fails++;
                    $display("FAIL frame_truncated: got %0d samples expected %0d", nbits, 2 * DW);
                end
                coll  = 1'b1;
                nbits = 0;
                fss_run++;
            end else if (coll) begin
                if (nbits == 0) begin
                    check("fss_width", fss_run, 2);
                    fss_run = 0;
                end
                samp[nbits] = ssptxd;
                nbits++;
                if (nbits == 2 * DW) begin
                    for (int i = 0; i < DW; i++) begin
                        check("bit_hold", samp[2*i+1], samp[2*i]);
                        mon_byte[DW-1-i] = samp[2*i];
                    end
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_frame: got %0h expected none", mon_byte);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (mon_byte !== e) begin
                            fails++;
                            $display("FAIL frame_byte: got %0h expected %0h at %0t", mon_byte, e, $time);
                        end else begin
                            $display("[TB] frame %02h ok at %0t", mon_byte, $time);
                        end
                    end
                    coll  = 1'b0;
                    nbits = 0;
                end
            end else begin
                check("idle_txd", ssptxd, 0);
            end
        end
    end

    task automatic write(input logic [7:0] d);
        psel   = 1'b1;
        pwrite = 1'b1;
        pwdata = d;
        @(negedge clk);
        psel   = 1'b0;
        pwrite = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_left != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("frames_done", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_sspclkout", sspclkout, 0);
        check("rst_ssptxd", ssptxd, 0);
        check("rst_sspfssout", sspfssout, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_empty", tx_empty, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_wr_drop", wr_drop, 0);
    endtask

    initial begin
        int n;
        // Reset with no clock edge in between.
        #3 clear_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        #2 clear_n = 1'b1;
        @(negedge clk);

        // Single byte.
        write(8'hA5);
        repeat (30) @(negedge clk);
        check("single_done", exp_q.size(), 0);

        // Fill and overflow with consecutive writes.
        for (int i = 1; i <= 6; i++) write(8'(i));
        drain();

        // Back-to-back frames.
        write(8'h80);
        write(8'h01);
        drain();

        // Push on the same edge as a chained pop with two entries queued.
        write(8'h11);
        write(8'h22);
        write(8'h33);
        n = 0;
        while (!(m_div && m_left == 1 && m_q.size() == 2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        write(8'h44);
        drain();

        // Reset in the middle of a frame.
        write(8'h3C);
        write(8'h77);
        n = 0;
        while (m_left != 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2 clear_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        #2 clear_n = 1'b1;
        @(negedge clk);
        write(8'h5A);
        drain();

        // Randomised traffic at varying write rates.
        for (int chunk = 0; chunk < 6; chunk++) begin
            int rate;
            rate = int'($urandom_range(5, 60));
            for (int c = 0; c < 300; c++) begin
                if (int'($urandom_range(0, 99)) < rate) begin
                    psel   = 1'b1;
                    pwrite = ($urandom_range(0, 3) != 0);
                end else begin
                    psel   = 1'($urandom_range(0, 1));
                    pwrite = 1'b0;
                end
                pwdata = 8'($urandom);
                @(negedge clk);
            end
        end
        psel   = 1'b0;
        pwrite = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
